// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Shares the register-file write port between pipeline write-back and
// debug register-load requests. Write-back always wins; one debug request
// is buffered until a free slot. If the buffered request loses MAX_WAIT
// consecutive edges, the pipeline is asked to freeze until it issues.
//
// Debug handshake: a request transfers on a rising edge where
// i_dbg_valid && o_dbg_ready. o_dbg_ready is high only while the buffer
// is empty and reset is low. o_dbg_done pulses for exactly one cycle
// when the buffered write reaches the register-file port.

module wb_write_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_write,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    input  logic        i_dbg_valid,
    input  logic [4:0]  i_dbg_reg,
    input  logic [31:0] i_dbg_data,
    output logic        o_dbg_ready,
    output logic        o_dbg_done,
    output logic        o_stall_req,
    output logic        o_rf_write,
    output logic [4:0]  o_rf_reg,
    output logic [31:0] o_rf_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t        state;
    logic [4:0]    buf_reg;
    logic [31:0]   buf_data;
    logic [CW-1:0] wait_cnt;
    logic          wb_eff;

    // A write-back to $zero is treated as an idle slot the debug write may use.
    assign wb_eff = i_wb_write && (i_wb_reg != 5'd0);

    // Ready only while the buffer is empty and the block is out of reset.
    assign o_dbg_ready = (state == IDLE) && !i_reset;

    // Stall request follows the registered STALL state directly.
    assign o_stall_req = (state == STALL);

    // Arbitration FSM with registered register-file outputs and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            buf_reg    <= 5'd0;
            buf_data   <= 32'd0;
            wait_cnt   <= '0;
            o_rf_write <= 1'b0;
            o_rf_reg   <= 5'd0;
            o_rf_data  <= 32'd0;
            o_dbg_done <= 1'b0;
        end else begin
            o_dbg_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Write-back passes straight through; a new request is
                    // only latched here, never issued on its accept edge.
                    o_rf_write <= wb_eff;
                    o_rf_reg   <= i_wb_reg;
                    o_rf_data  <= i_wb_data;
                    if (i_dbg_valid) begin
                        buf_reg  <= i_dbg_reg;
                        buf_data <= i_dbg_data;
                        wait_cnt <= '0;
                        state    <= PENDING;
                    end
                end
                PENDING, STALL: begin
                    if (!wb_eff) begin
                        // Free slot: issue the buffered write. A $zero target
                        // still completes but does not enable the write.
                        o_rf_write <= (buf_reg != 5'd0);
                        o_rf_reg   <= buf_reg;
                        o_rf_data  <= buf_data;
                        o_dbg_done <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= IDLE;
                    end else begin
                        // Write-back wins; count the lost edge, saturating.
                        o_rf_write <= 1'b1;
                        o_rf_reg   <= i_wb_reg;
                        o_rf_data  <= i_wb_data;
                        if (wait_cnt != MAX_CNT) begin
                            wait_cnt <= wait_cnt + CW'(1);
                            if (wait_cnt + CW'(1) == MAX_CNT) begin
                                state <= STALL;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the register-file write port between the pipeline write-back stage and the debug unit's register-load requests. Pipeline write-back always has priority. A debug request waits in a one-entry buffer until a cycle where write-back does not use the port. If the debug request is starved for too long, the block asks the pipeline controller to freeze the pipeline. It sits between the write-back stage outputs and the register-file write inputs.

## Interface
Parameters:
- `MAX_WAIT`, default 4: number of consecutive lost arbitration edges before a stall is requested; legal range ≥ 1.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_wb_write`  in  1  write-back write enable.
- `i_wb_reg`  in  5  write-back destination register.
- `i_wb_data`  in  32  write-back data.
- `i_dbg_valid`  in  1  debug write request valid.
- `i_dbg_reg`  in  5  debug destination register.
- `i_dbg_data`  in  32  debug write data.
- `o_dbg_ready`  out  1  buffer empty; a request is accepted on an edge where valid & ready.
- `o_dbg_done`  out  1  one-cycle pulse: the buffered debug write was issued this cycle.
- `o_stall_req`  out  1  request to freeze the pipeline (write-back must go idle).
- `o_rf_write`  out  1  register-file write enable (registered).
- `o_rf_reg`  out  5  register-file write address (registered).
- `o_rf_data`  out  32  register-file write data (registered).

## Operation
- Effective write-back: `wb_eff = i_wb_write && (i_wb_reg != 0)`. Writes to $zero are suppressed and count as an idle slot.
- Effective debug write: a debug request with `i_dbg_reg == 0` is accepted and completes normally (`o_dbg_done` pulses), but `o_rf_write` stays 0 for it.
- States:
  - IDLE: buffer empty, `o_dbg_ready = !i_reset`.
  - PENDING: buffer full, waiting for a free slot.
  - STALL: buffer full, `o_stall_req = 1`.
- IDLE → PENDING: on an edge with `i_dbg_valid && o_dbg_ready`. The register and data are latched, and `wait_cnt` is set to 0.
- PENDING/STALL, edge with `wb_eff = 0`:
  - The debug write is issued to `o_rf_*` and `o_dbg_done` = 1 for one cycle.
  - `wait_cnt` clears and the state returns to IDLE, so `o_stall_req` = 0 after this edge.
- PENDING, edge with `wb_eff = 1`:
  - The write-back write is issued and `wait_cnt` increments.
  - If the new `wait_cnt == MAX_WAIT`, go to STALL.
- STALL, edge with `wb_eff = 1`: the write-back write is issued. `wait_cnt` saturates (no wrap) and the state remains STALL.
- IDLE, every edge: `o_rf_*` take the write-back values, with `o_rf_write = wb_eff`.
- Same-register conflict: when write-back and buffered debug target the same register, write-back is written first and the debug value is written later. The debug value is the final register content.
- No bypass: a request accepted on edge N cannot issue before edge N+1.
- `wait_cnt` width is `$clog2(MAX_WAIT+1)`.

## Timing
- Write-back path latency: 1 cycle. Inputs sampled at edge N appear on `o_rf_*` after edge N.
- Debug path:
  - Accepted at edge N; earliest issue is edge N+1, with `o_rf_*` and `o_dbg_done` valid in cycle N+1.
  - `o_dbg_ready` returns to 1 after the issue edge, so the minimum request-to-request spacing is 2 cycles.
- Stall path:
  - `o_stall_req` rises after the MAX_WAIT-th lost edge.
  - It falls after the edge on which the debug write issues.
- Reset, while `i_reset` is high at an edge: state IDLE, buffer cleared, `wait_cnt` = 0.
  - Outputs: `o_rf_write` = 0, `o_rf_reg` = 0, `o_rf_data` = 0, `o_dbg_done` = 0, `o_stall_req` = 0.
  - `o_dbg_ready` = 0 while `i_reset` is high.
  - Reset during PENDING/STALL discards the buffered request without a done pulse.
- The first request can be accepted on the first edge after `i_reset` falls.

## Test plan
- WB only: `i_wb_write=1`, reg 15, data 0xABCD1234 → next cycle `o_rf_write=1`, `o_rf_reg=15`, `o_rf_data=0xABCD1234`. Then reg 0 → `o_rf_write=0`.
- Debug, idle pipeline: valid, reg 7, data 0x1234ABCD at edge N → ready=0 in cycle N. Cycle N+1: `o_rf_write=1`, reg 7, data 0x1234ABCD, `o_dbg_done=1`. Cycle N+2: ready=1, done=0.
- Contention: debug (reg 3, 0x55) accepted while WB writes every cycle; WB stops after 2 cycles → WB writes appear for 2 cycles, then the debug write, `o_stall_req` never asserted.
- Starvation, `MAX_WAIT=4`: WB writes continuously → `o_stall_req=1` after the 4th lost edge. WB idles one cycle later → debug write issued, done pulse, `o_stall_req=0` the cycle after.
- Same register: WB reg 9 = 0x1111 while debug reg 9 = 0x2222 pending → writes 0x1111 then 0x2222 in order.
- Reset mid-operation: assert `i_reset` in STALL → all outputs 0, no done pulse, ready=1 after release. A new request completes normally.
